bcd2bin_converter_4: RTL and testbench
======================================

Name: bcd2bin_converter_4

Overview:
Sequential BCD-to-binary converter. It is the inverse of the team's 4-digit binary-to-BCD converter.
- Takes four packed BCD digits (0..9999) and produces the unsigned binary value.
- Uses an iterative reverse double-dabble: one shift/correct step per clock.
- Sits between keypad/display-digit logic and arithmetic datapaths that need plain binary.

Parameters:
- OUTPUT_BIT_WIDTH, 14, width of the binary result and the number of iterations. Must be >= 14, since 9999 < 2^14.

Ports:
- Clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- Start  input  1  request a conversion. Sampled on the rising edge of Clk.
- Digit3  input  [0:3]  thousands digit. Bit 0 is the MSB.
- Digit2  input  [0:3]  hundreds digit.
- Digit1  input  [0:3]  tens digit.
- Digit0  input  [0:3]  units digit.
- Output  output  OUTPUT_BIT_WIDTH  binary result. Holds its value between conversions.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when Output has been updated.
- Error  output  1  invalid-digit flag. Valid together with Done.

Behaviour:
- Clock and reset: single clock domain (Clk). Reset is asynchronous and active-low on nReset.
- Reset (nReset=0, any time, including mid-conversion):
  - State goes to IDLE.
  - Output=0, Busy=0, Done=0, Error=0.
  - Iteration counter and work register are cleared.
  - Release is synchronous to the next Clk edge.
- States:
  - IDLE: wait for Start.
  - SHIFT: perform the iterations.
  - DONE: lasts exactly one cycle.
- IDLE or DONE with Start=1 at a rising edge:
  - Latch {Digit3,Digit2,Digit1,Digit0} into the 16-bit BCD part of the work register.
  - Clear the OUTPUT_BIT_WIDTH-bit binary part.
  - Set counter=OUTPUT_BIT_WIDTH and go to SHIFT. Busy=1 from the next cycle.
- SHIFT, per edge:
  - Shift {bcd,bin} right by 1; bcd LSB enters bin MSB.
  - Then, for each shifted 4-bit BCD digit >= 8, subtract 3 from that digit (all digits in parallel, same cycle).
  - Decrement counter. When counter reaches 0, go to DONE.
- DONE:
  - Output <= bin (registered on entry), Done=1, Busy=0.
  - Next edge: IDLE, unless Start=1, in which case back-to-back reload as above.
- Latency: Done is high in cycle N+OUTPUT_BIT_WIDTH+1 after the Start edge N. That is 15 cycles at default.
- Start while Busy=1: ignored. The conversion in progress is not disturbed.
- Digit inputs only need to be stable on the Start edge. Changes afterwards have no effect.
- Output changes only on entry to DONE (or on reset). No glitches between conversions.
- Done and Busy are never high in the same cycle.
- OUTPUT_BIT_WIDTH > 14: extra iterations shift zeros. The upper result bits are 0.

Optional Feature:
- Macro: BCD2BIN_INPUT_CHECK_EN.
- Defined:
  - At the Start edge, any digit > 9 skips SHIFT and goes directly to DONE on the next edge.
  - That DONE has Error=1 and Output=0; latency is 1 cycle.
  - Error clears on the next Start acceptance or on reset.
- Not defined:
  - Error is tied to 0 and no checking logic is synthesized.
  - Invalid digits run the normal algorithm. The result is deterministic but unspecified.

Test Plan:
- Reset, then Start with digits 0,0,0,0 -> after 15 cycles Done=1, Output=0, Error=0; Busy=1 for exactly 14 cycles before it.
- Sequential Starts with 0,0,1,0 / 0,1,4,2 / 0,0,8,9 / 0,5,9,9 -> Output 10, 142, 89, 599 respectively, each with a one-cycle Done.
- Digits 9,9,9,9 -> Output=9999 (0x270F). Then Start held high through DONE with 1,2,3,4 -> back-to-back result 1234 15 cycles later.
- Start with 0,1,4,2; pulse Start with 5,5,5,5 at cycle 5 while Busy -> result still 142; no extra Done.
- nReset low at cycle 7 of a conversion of 0,5,9,9 -> Output, Busy, Done and Error all 0 immediately (asynchronous). After release, a new Start with 0,0,3,3 -> Output 33.
- With BCD2BIN_INPUT_CHECK_EN: digits 0,0,1,12 -> Done after 1 cycle with Error=1, Output=0. Next Start with 0,0,3,3 -> Error=0, Output=33.

Source files
------------

// File: rtl/bcd2bin_converter_4.sv
// -----------------------------------------------------------------------------
// bcd2bin_converter_4
//
// Sequential 4-digit BCD to unsigned binary converter (reverse double-dabble).
// One shift/correct step per clock; OUTPUT_BIT_WIDTH steps per conversion.
// This is the inverse of the 4-digit binary-to-BCD converter.
//
// Parameters:
//   OUTPUT_BIT_WIDTH  width of the binary result and the iteration count
//                     (>= 14, since 9999 < 2^14)
//
// Ports:
//   Clk              system clock, rising edge
//   nReset           asynchronous active-low reset
//   Start            conversion request, accepted in IDLE or DONE
//   Digit3..Digit0   packed BCD digits, thousands..units, bit 0 is the MSB
//   Output           binary result, updated only on entry to DONE
//   Busy             high while iterating
//   Done             one-cycle pulse when Output has been updated
//   Error            invalid-digit flag, valid together with Done
//
// Optional feature macro: BCD2BIN_INPUT_CHECK_EN
//   Defined   : a digit > 9 at the Start edge skips the iterations, the next
//               cycle is DONE with Error=1 and Output=0.
//   Undefined : Error is tied low and invalid digits run the normal algorithm.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for Start
// SHIFT  | iterating, one shift/correct step per clock
// DONE   | Output just updated, Done pulse; Start here reloads directly
// -----------------------------------------------------------------------------
module bcd2bin_converter_4 #(
  parameter int OUTPUT_BIT_WIDTH = 14
) (
  input  logic                        Clk,
  input  logic                        nReset,
  input  logic                        Start,
  input  logic [0:3]                  Digit3,
  input  logic [0:3]                  Digit2,
  input  logic [0:3]                  Digit1,
  input  logic [0:3]                  Digit0,
  output logic [OUTPUT_BIT_WIDTH-1:0] Output,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Error
);

  localparam int W  = OUTPUT_BIT_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Work register: BCD part on the left, binary part on the right.
  logic [15:0]   bcd_q;
  logic [W-1:0]  bin_q;
  logic [CW-1:0] cnt_q;

  logic [15:0]   bcd_in;
  logic [15:0]   bcd_sh;
  logic [15:0]   bcd_step;
  logic [W-1:0]  bin_step;
  logic          start_ok;
  logic          last_step;
  logic          digit_bad;

  // Concatenating the [0:3] digits keeps each digit's MSB on the left.
  assign bcd_in    = {Digit3, Digit2, Digit1, Digit0};
  assign start_ok  = Start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_step = (cnt_q == CNT_ONE);

  // One reverse double-dabble step: shift {bcd,bin} right by one, then pull
  // every BCD digit that landed at >= 8 back down by 3 (all digits at once).
  assign bcd_sh   = {1'b0, bcd_q[15:1]};
  assign bin_step = {bcd_q[0], bin_q[W-1:1]};

  always_comb begin
    bcd_step = bcd_sh;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8) begin
        bcd_step[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD2BIN_INPUT_CHECK_EN
  logic err_q;

  assign digit_bad = (Digit3 > 4'd9) || (Digit2 > 4'd9) ||
                     (Digit1 > 4'd9) || (Digit0 > 4'd9);

  // Error is re-evaluated on every accepted Start and held until the next one.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= digit_bad;
    end
  end

  assign Error = err_q;
`else
  assign digit_bad = 1'b0;
  assign Error     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_nxt = digit_bad ? ST_DONE : ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_step) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Busy and Done decode mutually exclusive states)
  // ---------------------------------------------------------------------------
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state)
      ST_SHIFT: Busy = 1'b1;
      ST_DONE:  Done = 1'b1;
      default: begin
        Busy = 1'b0;
        Done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: work register, iteration counter and result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      Output <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            if (digit_bad) begin
              bcd_q  <= '0;
              bin_q  <= '0;
              cnt_q  <= '0;
              Output <= '0;
            end else begin
              bcd_q <= bcd_in;
              bin_q <= '0;
              cnt_q <= CNT_LOAD;
            end
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_step;
          bin_q <= bin_step;
          cnt_q <= cnt_q - CNT_ONE;
          // The result of the final step is captured as DONE is entered,
          // so Output never shows partial values.
          if (last_step) begin
            Output <= bin_step;
          end
        end
        default: begin
          bcd_q <= bcd_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_converter_4.sv
module tb_bcd2bin_converter_4;

  localparam int W = 14;

  logic         Clk;
  logic         nReset;
  logic         Start;
  logic [0:3]   Digit3, Digit2, Digit1, Digit0;
  logic [W-1:0] Output;
  logic         Busy, Done, Error;

  int checks = 0;
  int errors = 0;

  bcd2bin_converter_4 #(.OUTPUT_BIT_WIDTH(W)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .Start  (Start),
    .Digit3 (Digit3),
    .Digit2 (Digit2),
    .Digit1 (Digit1),
    .Digit0 (Digit0),
    .Output (Output),
    .Busy   (Busy),
    .Done   (Done),
    .Error  (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: BCD digits weighted by powers of ten.
  function automatic int ref_value(input logic [3:0] d3, d2, d1, d0);
    return int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0);
  endfunction

  // Drive one Start pulse and wait for Done; reports what was seen.
  task automatic run_conv(input logic [3:0] d3, d2, d1, d0,
                          output int busy_n, output logic [W-1:0] out_v,
                          output logic err_v, output bit seen_done,
                          output bit overlap);
    @(negedge Clk);
    Digit3 = d3; Digit2 = d2; Digit1 = d1; Digit0 = d0;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    Digit3 = 4'($urandom_range(0, 15));
    Digit2 = 4'($urandom_range(0, 15));
    busy_n = 0; seen_done = 0; overlap = 0; out_v = '0; err_v = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (Busy && Done) overlap = 1;
      if (Done) begin
        seen_done = 1; out_v = Output; err_v = Error;
        break;
      end
      if (Busy) busy_n++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0; Start = 1'b0;
    Digit3 = '0; Digit2 = '0; Digit1 = '0; Digit0 = '0;
    #3;
    checks++; if (Output !== '0) begin errors++; $display("FAIL reset_output: got %0d expected 0", Output); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    checks++; if (Error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", Error); end
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", Busy, Done); end
  endtask

  task automatic test_conversions();
    logic [3:0] tbl [0:4][0:3];
    logic [3:0] d [0:3];
    int busy_n, expv;
    logic [W-1:0] out_v;
    logic err_v;
    bit seen, ovl;
    tbl[0] = '{4'd0, 4'd0, 4'd0, 4'd0};
    tbl[1] = '{4'd0, 4'd0, 4'd1, 4'd0};
    tbl[2] = '{4'd0, 4'd1, 4'd4, 4'd2};
    tbl[3] = '{4'd0, 4'd0, 4'd8, 4'd9};
    tbl[4] = '{4'd0, 4'd5, 4'd9, 4'd9};
    for (int n = 0; n < 5 + 16; n++) begin
      for (int k = 0; k < 4; k++) begin
        d[k] = (n < 5) ? tbl[n][k] : 4'($urandom_range(0, 9));
      end
      expv = ref_value(d[0], d[1], d[2], d[3]);
      run_conv(d[0], d[1], d[2], d[3], busy_n, out_v, err_v, seen, ovl);
      checks++; if (!seen) begin errors++; $display("FAIL conv_done_seen[%0d]: no Done within budget", n); end
      checks++; if (ovl) begin errors++; $display("FAIL conv_busy_done_overlap[%0d]: Busy and Done both high", n); end
      checks++; if (busy_n != W) begin errors++; $display("FAIL conv_busy_cycles[%0d]: got %0d expected %0d", n, busy_n, W); end
      checks++; if (out_v !== W'(expv)) begin errors++; $display("FAIL conv_output[%0d]: got %0d expected %0d", n, out_v, expv); end
      checks++; if (err_v !== 1'b0) begin errors++; $display("FAIL conv_error[%0d]: got %b expected 0", n, err_v); end
      repeat (1 + (n % 3)) @(negedge Clk);
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL conv_done_pulse[%0d]: Done still high", n); end
      checks++; if (Output !== W'(expv)) begin errors++; $display("FAIL conv_output_hold[%0d]: got %0d expected %0d", n, Output, expv); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] first_out;
    bit seen;
    int busy_n;
    @(negedge Clk);
    Digit3 = 4'd9; Digit2 = 4'd9; Digit1 = 4'd9; Digit0 = 4'd9;
    Start = 1'b1;
    @(negedge Clk);
    Digit3 = 4'd1; Digit2 = 4'd2; Digit1 = 4'd3; Digit0 = 4'd4;
    seen = 0; first_out = '0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin seen = 1; first_out = Output; break; end
      @(negedge Clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_first_done: no Done within budget"); end
    checks++; if (first_out !== W'(ref_value(4'd9, 4'd9, 4'd9, 4'd9))) begin errors++; $display("FAIL b2b_first_output: got %0d expected 9999", first_out); end
    @(negedge Clk);
    Start = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_reload_busy: got %b expected 1", Busy); end
    busy_n = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin seen = 1; break; end
      if (Busy) busy_n++;
      @(negedge Clk);
    end
    checks++; if (!seen || busy_n != W) begin errors++; $display("FAIL b2b_second_latency: done=%0d busy_cycles=%0d expected 1 %0d", seen, busy_n, W); end
    checks++; if (Output !== W'(ref_value(4'd1, 4'd2, 4'd3, 4'd4))) begin errors++; $display("FAIL b2b_second_output: got %0d expected 1234", Output); end
  endtask

  task automatic test_start_while_busy();
    int done_n;
    logic [W-1:0] out_at_done;
    @(negedge Clk);
    Digit3 = 4'd0; Digit2 = 4'd1; Digit1 = 4'd4; Digit0 = 4'd2;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Digit3 = 4'd5; Digit2 = 4'd5; Digit1 = 4'd5; Digit0 = 4'd5;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    done_n = 0; out_at_done = '0;
    for (int i = 0; i < 30; i++) begin
      if (Done) begin done_n++; out_at_done = Output; end
      @(negedge Clk);
    end
    checks++; if (done_n != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", done_n); end
    checks++; if (out_at_done !== W'(142)) begin errors++; $display("FAIL busy_start_output: got %0d expected 142", out_at_done); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: Busy=%b expected 0", Busy); end
  endtask

  task automatic test_reset_mid();
    int busy_n;
    logic [W-1:0] out_v;
    logic err_v;
    bit seen, ovl;
    @(negedge Clk);
    Digit3 = 4'd0; Digit2 = 4'd5; Digit1 = 4'd9; Digit0 = 4'd9;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (6) @(negedge Clk);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", Busy); end
    #2 nReset = 1'b0;
    #1;
    checks++; if (Output !== '0 || Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0)
      begin errors++; $display("FAIL midrst_async_clear: out=%0d busy=%b done=%b err=%b expected all 0", Output, Busy, Done, Error); end
    @(negedge Clk);
    nReset = 1'b1;
    run_conv(4'd0, 4'd0, 4'd3, 4'd3, busy_n, out_v, err_v, seen, ovl);
    checks++; if (!seen || busy_n != W || out_v !== W'(33))
      begin errors++; $display("FAIL midrst_next_conv: done=%0d busy=%0d out=%0d expected 1 %0d 33", seen, busy_n, out_v, W); end
  endtask

  task automatic test_invalid_digit();
    int busy_n;
    logic [W-1:0] out_v;
    logic err_v;
    bit seen, ovl;
    run_conv(4'd0, 4'd0, 4'd1, 4'd12, busy_n, out_v, err_v, seen, ovl);
`ifdef BCD2BIN_INPUT_CHECK_EN
    checks++; if (!seen || busy_n != 0) begin errors++; $display("FAIL invalid_latency: done=%0d busy_cycles=%0d expected 1 0", seen, busy_n); end
    checks++; if (err_v !== 1'b1) begin errors++; $display("FAIL invalid_error: got %b expected 1", err_v); end
    checks++; if (out_v !== '0) begin errors++; $display("FAIL invalid_output: got %0d expected 0", out_v); end
`else
    checks++; if (!seen || busy_n != W) begin errors++; $display("FAIL invalid_nocheck_latency: done=%0d busy_cycles=%0d expected 1 %0d", seen, busy_n, W); end
    checks++; if (err_v !== 1'b0) begin errors++; $display("FAIL invalid_nocheck_error: got %b expected 0", err_v); end
`endif
    run_conv(4'd0, 4'd0, 4'd3, 4'd3, busy_n, out_v, err_v, seen, ovl);
    checks++; if (!seen || err_v !== 1'b0 || out_v !== W'(33))
      begin errors++; $display("FAIL invalid_recover: done=%0d err=%b out=%0d expected 1 0 33", seen, err_v, out_v); end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    test_invalid_digit();
    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
